// File: rtl/owr_reset_presence.sv
// 1-Wire bus master reset/presence sequencer: drives the reset-low pulse, releases the bus,
// samples the slave presence pulse and flags a shorted line. Optional macro: OWR_OVERDRIVE_EN.
module owr_reset_presence #(
    parameter int CLK_PER_US = 1,
    parameter int T_RSTL_US  = 480,
    parameter int T_MSP_US   = 70,
    parameter int T_RSTH_US  = 480
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
`ifdef OWR_OVERDRIVE_EN
    input  logic od,
`endif
    input  logic bus_in,
    output logic bus_oe,
    output logic busy,
    output logic done,
    output logic presence,
    output logic short_det
);
    localparam int N_RSTL = T_RSTL_US * CLK_PER_US;
    localparam int N_MSP  = T_MSP_US  * CLK_PER_US;
    localparam int N_RSTH = T_RSTH_US * CLK_PER_US;
`ifdef OWR_OVERDRIVE_EN
    localparam int OD_RSTL = 48 * CLK_PER_US;
    localparam int OD_MSP  = 8  * CLK_PER_US;
    localparam int OD_RSTH = 48 * CLK_PER_US;
    localparam int MAX_A   = (N_RSTL > N_RSTH) ? N_RSTL : N_RSTH;
    localparam int MAX_B   = (OD_RSTL > OD_RSTH) ? OD_RSTL : OD_RSTH;
    localparam int MAX_CNT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
`else
    localparam int MAX_CNT = (N_RSTL > N_RSTH) ? N_RSTL : N_RSTH;
`endif
    localparam int CW = $clog2(MAX_CNT + 1);

    typedef logic [CW-1:0] cnt_t;
    typedef enum logic [1:0] {IDLE, LOW, REL, DONE} state_t;

    state_t state, state_n;
    cnt_t   cnt, cnt_n;
    logic   pres_n, short_n;
    logic   sync1, bus_s;
    cnt_t   low_ld, rel_ld, msp_at;

    // Counter runs down from N-1 through REL, so the sample point sits at N_RSTH-1-N_MSP.
`ifdef OWR_OVERDRIVE_EN
    logic od_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            od_q <= 1'b0;
        else if (state == IDLE && start)
            od_q <= od;
    end

    always_comb begin
        low_ld = od   ? cnt_t'(OD_RSTL - 1) : cnt_t'(N_RSTL - 1);
        rel_ld = od_q ? cnt_t'(OD_RSTH - 1) : cnt_t'(N_RSTH - 1);
        msp_at = od_q ? cnt_t'(OD_RSTH - 1 - OD_MSP) : cnt_t'(N_RSTH - 1 - N_MSP);
    end
`else
    always_comb begin
        low_ld = cnt_t'(N_RSTL - 1);
        rel_ld = cnt_t'(N_RSTH - 1);
        msp_at = cnt_t'(N_RSTH - 1 - N_MSP);
    end
`endif

    // Idle line is high, so the synchroniser resets to 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            bus_s <= 1'b1;
        end else begin
            sync1 <= bus_in;
            bus_s <= sync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            presence  <= 1'b0;
            short_det <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            presence  <= pres_n;
            short_det <= short_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pres_n  = presence;
        short_n = short_det;
        case (state)
            IDLE: if (start) begin
                pres_n  = 1'b0;
                short_n = 1'b0;
                if (bus_s) begin
                    state_n = LOW;
                    cnt_n   = low_ld;
                end else begin
                    state_n = DONE;
                    short_n = 1'b1;
                    cnt_n   = '0;
                end
            end
            LOW: begin
                if (cnt == '0) begin
                    state_n = REL;
                    cnt_n   = rel_ld;
                end else begin
                    cnt_n = cnt - cnt_t'(1);
                end
            end
            REL: begin
                if (cnt == msp_at)
                    pres_n = ~bus_s;
                if (cnt == '0)
                    state_n = DONE;
                else
                    cnt_n = cnt - cnt_t'(1);
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Decoded straight from state so an asynchronous reset releases the bus at once.
    assign bus_oe = (state == LOW);
    assign busy   = (state == LOW) || (state == REL);
    assign done   = (state == DONE);
endmodule
